// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizing for the countdown timer.
// The optional prescaler is selected by COUNTDOWN_TIMER_PRESCALE_EN.
package countdown_timer_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_PRESCALE_DIV = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Free-running divider emitting a one-cycle tick every DIV clocks.
// Instantiated only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, abort and done pulse.
// Define COUNTDOWN_TIMER_PRESCALE_EN to decrement once every PRESCALE_DIV cycles.
//
// state | meaning
// IDLE  | waiting for start; count holds 0
// RUN   | counting down; busy high
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int PRESCALE_DIV = DEF_PRESCALE_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             start_acc;
    logic             tick;

    if (PRESCALE_DIV < 2) begin : g_bad_div
        $error("countdown_timer: PRESCALE_DIV must be >= 2");
    end

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    tick_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start_acc || abort),
        .tick_o  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort has priority over start even while idle
                if (start && !abort) begin
                    if (load_val != '0) begin
                        count_d   = load_val;
                        reload_d  = load_val;
                        mode_d    = auto_reload;
                        state_d   = ST_RUN;
                        start_acc = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (tick && count_q == WIDTH'(1)) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (tick && count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; {busy,done,count} checked per cycle.
// Build with COUNTDOWN_TIMER_PRESCALE_EN defined to exercise the prescaled variant.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] load_val = '0;
    logic        auto_reload = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic [15:0] count;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    countdown_timer #(
        .WIDTH        (16),
        .PRESCALE_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .abort       (abort),
        .busy        (busy),
        .count       (count),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL reset: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_release: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
    endtask

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [17:0] exp;
        start = 1'b1; load_val = 16'd3; auto_reload = 1'b0;
        step();
        start = 1'b0; load_val = '0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) step();
            exp = {1'b0, 1'b0, 16'd0};
            if (k < 12) exp = {1'b1, 1'b0, 16'(3 - k / 4)};
            if (k == 12) exp = {1'b0, 1'b1, 16'd0};
            n_cmp++;
            if ({busy, done, count} !== exp) begin
                n_err++;
                $display("FAIL prescale k=%0d: busy/done/count got %0b/%0b/%0d expected %0b/%0b/%0d",
                         k, busy, done, count, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask
`else
    task automatic test_oneshot();
        logic [17:0] exp;
        start = 1'b1; load_val = 16'd5; auto_reload = 1'b0;
        step();
        start = 1'b0; load_val = '0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            exp = {1'(k < 5), 1'(k == 5), 16'(k < 5 ? 5 - k : 0)};
            n_cmp++;
            if ({busy, done, count} !== exp) begin
                n_err++;
                $display("FAIL oneshot k=%0d: busy/done/count got %0b/%0b/%0d expected %0b/%0b/%0d",
                         k, busy, done, count, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [17:0] exp;
        start = 1'b1; load_val = 16'd3; auto_reload = 1'b1;
        step();
        start = 1'b0; load_val = '0; auto_reload = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            exp = {1'b1, 1'(k > 0 && k % 3 == 0), 16'(k % 3 == 0 ? 3 : 3 - k % 3)};
            n_cmp++;
            if ({busy, done, count} !== exp) begin
                n_err++;
                $display("FAIL auto_reload k=%0d: busy/done/count got %0b/%0b/%0d expected %0b/%0b/%0d",
                         k, busy, done, count, exp[17], exp[16], exp[15:0]);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL auto_reload_stop: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
    endtask

    task automatic test_reload_one();
        start = 1'b1; load_val = 16'd1; auto_reload = 1'b1;
        step();
        start = 1'b0; load_val = '0; auto_reload = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if ({busy, done, count} !== {1'b1, 1'b1, 16'd1}) begin
                n_err++;
                $display("FAIL reload_one k=%0d: busy/done/count got %0b/%0b/%0d expected 1/1/1", k, busy, done, count);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        logic seen_done = 1'b0;
        start = 1'b1; load_val = 16'd6; auto_reload = 1'b0;
        step();
        start = 1'b0; load_val = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            seen_done |= done;
        end
        n_cmp++;
        if ({busy, count} !== {1'b1, 16'd2}) begin
            n_err++;
            $display("FAIL abort_pre: busy/count got %0b/%0d expected 1/2", busy, count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL abort_stop: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            seen_done |= done;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done seen %0b expected 0", seen_done);
        end
        start = 1'b1; abort = 1'b1; load_val = 16'd5;
        step();
        start = 1'b0; abort = 1'b0; load_val = '0;
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL abort_start_idle: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
        step();
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL abort_start_idle2: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
    endtask

    task automatic test_zero_load();
        start = 1'b1; load_val = 16'd0;
        step();
        start = 1'b0;
        n_cmp++;
        if ({busy, done, count} !== {1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL zero_load: busy/done/count got %0b/%0b/%0d expected 0/1/0", busy, done, count);
        end
        step();
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL zero_load_after: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
    endtask

    task automatic test_start_in_run();
        logic [17:0] exp;
        start = 1'b1; load_val = 16'd4; auto_reload = 1'b0;
        step();
        load_val = 16'd9; auto_reload = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) begin
                start = 1'b0; load_val = '0; auto_reload = 1'b0;
            end
            exp = {1'(k < 4), 1'(k == 4), 16'(k < 4 ? 4 - k : 0)};
            n_cmp++;
            if ({busy, done, count} !== exp) begin
                n_err++;
                $display("FAIL start_in_run k=%0d: busy/done/count got %0b/%0b/%0d expected %0b/%0b/%0d",
                         k, busy, done, count, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] exp;
        start = 1'b1; load_val = 16'd10;
        step();
        start = 1'b0; load_val = '0;
        for (int k = 1; k <= 3; k++) step();
        n_cmp++;
        if ({busy, count} !== {1'b1, 16'd7}) begin
            n_err++;
            $display("FAIL async_pre: busy/count got %0b/%0d expected 1/7", busy, count);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, count} !== 18'd0) begin
            n_err++;
            $display("FAIL async_reset: busy/done/count got %0b/%0b/%0d expected 0/0/0", busy, done, count);
        end
        #2 rst = 1'b0;
        start = 1'b1; load_val = 16'd2;
        step();
        start = 1'b0; load_val = '0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            exp = {1'(k < 2), 1'(k == 2), 16'(k < 2 ? 2 - k : 0)};
            n_cmp++;
            if ({busy, done, count} !== exp) begin
                n_err++;
                $display("FAIL after_reset k=%0d: busy/done/count got %0b/%0b/%0d expected %0b/%0b/%0d",
                         k, busy, done, count, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
        test_prescale();
`else
        test_oneshot();
        test_auto_reload();
        test_reload_one();
        test_abort();
        test_zero_load();
        test_start_in_run();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter, the counterpart to the team's free-running 4-bit up counter.
- Software or an FSM loads a start value and starts the timer. The timer counts down to zero and emits a one-cycle done pulse.
- Supports one-shot and auto-reload (periodic) modes, and abort.
- Used as the timeout/interval source for control FSMs elsewhere in the design.

Parameters:
- WIDTH, 16, bit width of load_val and count.
- PRESCALE_DIV, 4, clock cycles per decrement tick. Used only when PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  start request; sampled in IDLE only.
- load_val  input  WIDTH  initial count; sampled with start.
- auto_reload  input  1  periodic mode select; sampled with start.
- abort  input  1  cancels a running count.
- busy  output  1  high while in RUN.
- count  output  WIDTH  current remaining count (registered).
- done  output  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (asynchronous, any time including mid-count):
  - state=IDLE, count=0, busy=0, done=0.
  - Reload register=0, mode=one-shot.
  - Prescaler cleared.
- States: IDLE, RUN. Two-state FSM with registered outputs only.
- IDLE, start=1, load_val!=0:
  - count<=load_val, reload<=load_val, mode<=auto_reload.
  - busy<=1, go to RUN.
- IDLE, start=1, load_val==0:
  - done<=1 for one cycle, count stays 0, stay IDLE, busy stays 0.
- IDLE, start=0: hold. count retains its last value.
- RUN, each tick (every cycle without prescaler):
  - count<=count-1.
- RUN, tick and count==1 (terminal):
  - done<=1 for exactly one cycle.
  - One-shot: count<=0, busy<=0, go to IDLE.
  - Auto-reload: count<=reload, stay in RUN, busy stays 1.
- Latency: start sampled at edge E0 with load_val=N gives count=N after E0, and done high during the cycle following edge E0+N. Auto-reload period is exactly N ticks.
- start while in RUN is ignored: no restart, load_val not sampled.
- abort in RUN:
  - Next edge: count<=0, busy<=0, go to IDLE, done stays 0.
  - abort beats terminal count in the same cycle, so no done pulse.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, start ignored.
- Arithmetic: unsigned, modulo 2^WIDTH. The count==0 state is never decremented in RUN, so there is no underflow.
- done is never high for two consecutive cycles except in auto-reload with N=1, where it stays high every tick.

Optional Feature:
- Macro: COUNTDOWN_TIMER_PRESCALE_EN.
- Defined:
  - A prescaler counter of width $clog2(PRESCALE_DIV) generates tick once every PRESCALE_DIV cycles.
  - The prescaler is cleared when start is accepted and on abort/reset.
  - Latency from start to done = N*PRESCALE_DIV cycles.
  - In auto-reload mode the prescaler free-runs, so the period stays exact.
- Undefined: tick is tied to 1, PRESCALE_DIV is ignored, and no prescaler flops exist.

Decomposition:
- Package countdown_timer_pkg:
  - State enum (IDLE, RUN).
  - Default WIDTH and PRESCALE_DIV constants.
- One natural sub-module: tick_prescaler.
  - Counter plus terminal-compare producing a tick.
  - Instantiated only under COUNTDOWN_TIMER_PRESCALE_EN.
- The FSM and down-counter stay in the top module.

Test Plan:
- Reset then start with load_val=5 (no prescale): count goes 5,4,3,2,1,0. done is high in exactly the 5th cycle after the start edge, then busy=0 and state is IDLE.
- Auto-reload with load_val=3: done pulses every 3 cycles for at least 4 periods. count sequence is 3,2,1,3,2,1… and busy stays 1.
- abort asserted when count=2 during a load_val=6 run: next cycle count=0, busy=0, and no done pulse ever. abort together with start in IDLE: the timer does not start.
- start with load_val=0: done is high one cycle later, busy never asserts. start pulsed again during a RUN with load_val=4: count is unaffected.
- rst asserted asynchronously mid-count (count=7 of 10): count=0, busy=0 and done=0 immediately, without waiting for a clock edge. A fresh start afterwards behaves normally.
- With COUNTDOWN_TIMER_PRESCALE_EN and PRESCALE_DIV=4, load_val=3: done arrives 12 cycles after the start edge, and count decrements only every 4th cycle.
